// File: rtl/tlul_req_arbiter.sv
// rtl/tlul_req_arbiter.sv - round-robin arbiter sharing one TL-UL master port
// between N_REQ valid/ready requesters, one outstanding transaction at a time.
module tlul_req_arbiter #(
  parameter int N_REQ   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [N_REQ-1:0]      i_req_we,
  input  logic [N_REQ*AW-1:0]   i_req_addr,
  input  logic [N_REQ*DW-1:0]   i_req_wdata,
  input  logic [N_REQ*DW/8-1:0] i_req_mask,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [N_REQ-1:0]      o_rsp_valid,
  output logic [DW-1:0]         o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_a_valid,
  input  logic                  i_a_ready,
  output logic [2:0]            o_a_opcode,
  output logic [2:0]            o_a_param,
  output logic [1:0]            o_a_size,
  output logic [SRC_W-1:0]      o_a_source,
  output logic [AW-1:0]         o_a_address,
  output logic [DW/8-1:0]       o_a_mask,
  output logic [DW-1:0]         o_a_data,
  input  logic                  i_d_valid,
  output logic                  o_d_ready,
  input  logic [2:0]            i_d_opcode,
  input  logic [SRC_W-1:0]      i_d_source,
  input  logic [DW-1:0]         i_d_data,
  input  logic                  i_d_error,
  output logic                  o_proto_err
);

  localparam int MW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] SIZE = 2'($clog2(MW));

  typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT} state_t;

  state_t            state, state_d;
  logic [SRC_W-1:0]  rr_ptr, rr_ptr_d, gnt, gnt_d;
  logic              gnt_we, gnt_we_d;
  logic [CW-1:0]     cnt, cnt_d;

  logic [N_REQ-1:0]  req_ready_d, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_d, a_data_d;
  logic              rsp_err_d, a_valid_d, d_ready_d, proto_err_d;
  logic [2:0]        a_opcode_d, a_param_d;
  logic [1:0]        a_size_d;
  logic [SRC_W-1:0]  a_source_d;
  logic [AW-1:0]     a_address_d;
  logic [MW-1:0]     a_mask_d;

  logic              found_hi, found_lo, done;
  logic [SRC_W-1:0]  sel_hi, sel_lo, sel;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic [MW-1:0]     sel_mask;

  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    // Descending scan so the lowest qualifying index is the one left standing.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        found_lo = 1'b1;
        sel_lo   = SRC_W'(k);
        if (SRC_W'(k) >= rr_ptr) begin
          found_hi = 1'b1;
          sel_hi   = SRC_W'(k);
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;

    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel == SRC_W'(k)) begin
        sel_we    = i_req_we[k];
        sel_addr  = i_req_addr[k*AW +: AW];
        sel_wdata = i_req_wdata[k*DW +: DW];
        sel_mask  = i_req_mask[k*MW +: MW];
      end
    end
  end

  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    gnt_d       = gnt;
    gnt_we_d    = gnt_we;
    cnt_d       = cnt;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = o_rsp_rdata;
    rsp_err_d   = o_rsp_err;
    a_valid_d   = o_a_valid;
    a_opcode_d  = o_a_opcode;
    a_param_d   = o_a_param;
    a_size_d    = o_a_size;
    a_source_d  = o_a_source;
    a_address_d = o_a_address;
    a_mask_d    = o_a_mask;
    a_data_d    = o_a_data;
    d_ready_d   = o_d_ready;
    proto_err_d = o_proto_err;
    done        = 1'b0;

    unique case (state)
      IDLE: begin
        if (found_hi || found_lo) begin
          gnt_d       = sel;
          gnt_we_d    = sel_we;
          a_valid_d   = 1'b1;
          a_param_d   = 3'd0;
          a_size_d    = SIZE;
          a_source_d  = sel;
          a_address_d = sel_addr;
          if (sel_we) begin
            a_opcode_d = (sel_mask == {MW{1'b1}}) ? 3'd0 : 3'd1;
            a_mask_d   = sel_mask;
            a_data_d   = sel_wdata;
          end else begin
            a_opcode_d = 3'd4;
            a_mask_d   = {MW{1'b1}};
            a_data_d   = '0;
          end
          for (int k = 0; k < N_REQ; k++) req_ready_d[k] = (sel == SRC_W'(k));
          state_d = A_SEND;
        end
      end
      A_SEND: begin
        if (i_a_ready) begin
          a_valid_d = 1'b0;
          d_ready_d = 1'b1;
          cnt_d     = '0;
          state_d   = D_WAIT;
        end
      end
      D_WAIT: begin
        if (i_d_valid && i_d_source == gnt) begin
          done        = 1'b1;
          rsp_rdata_d = i_d_data;
          rsp_err_d   = i_d_error | (i_d_opcode != (gnt_we ? 3'd0 : 3'd1));
        end else begin
          // Beats for another source are swallowed; the timeout keeps running.
          if (i_d_valid) proto_err_d = 1'b1;
          if (cnt == CW'(TIMEOUT - 1)) begin
            done        = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        if (done) begin
          for (int k = 0; k < N_REQ; k++) rsp_valid_d[k] = (gnt == SRC_W'(k));
          d_ready_d = 1'b0;
          rr_ptr_d  = (gnt == SRC_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt         <= '0;
      gnt_we      <= 1'b0;
      cnt         <= '0;
      o_req_ready <= '0;
      o_rsp_valid <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      o_a_valid   <= 1'b0;
      o_a_opcode  <= '0;
      o_a_param   <= '0;
      o_a_size    <= '0;
      o_a_source  <= '0;
      o_a_address <= '0;
      o_a_mask    <= '0;
      o_a_data    <= '0;
      o_d_ready   <= 1'b0;
      o_proto_err <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      gnt         <= gnt_d;
      gnt_we      <= gnt_we_d;
      cnt         <= cnt_d;
      o_req_ready <= req_ready_d;
      o_rsp_valid <= rsp_valid_d;
      o_rsp_rdata <= rsp_rdata_d;
      o_rsp_err   <= rsp_err_d;
      o_a_valid   <= a_valid_d;
      o_a_opcode  <= a_opcode_d;
      o_a_param   <= a_param_d;
      o_a_size    <= a_size_d;
      o_a_source  <= a_source_d;
      o_a_address <= a_address_d;
      o_a_mask    <= a_mask_d;
      o_a_data    <= a_data_d;
      o_d_ready   <= d_ready_d;
      o_proto_err <= proto_err_d;
    end
  end

endmodule
